axis_mash_rate_ctrl: RTL

Sample-rate sequencer in front of the MASH 1-1 modulator. It accepts audio-rate samples on an AXI-Stream slave and presents each one to the modulator input for exactly `cfg_osr` accepted modulator beats (zero-order-hold upsampling). It buffers one sample ahead, holds midscale while disabled, and reports underflows when the source fails to deliver in time.

---
 rtl/axis_mash_rate_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/axis_mash_rate_ctrl.sv
// ---------------------------------------------------------------------------
// axis_mash_rate_ctrl
//
// Sample-rate sequencer placed in front of the MASH 1-1 modulator. Audio-rate
// samples arrive on an AXI-Stream slave. Each sample is presented to the
// modulator for exactly osr_q accepted beats, which gives zero-order-hold
// upsampling. One sample is buffered ahead of the one being output. The
// output holds midscale while the block is disabled. An underflow is counted
// whenever a hold period ends and no buffered sample is ready to replace it.
//
// Ports:
//   aclk, arst_n          clock, asynchronous active-low reset
//   cfg_enable            run request; dropping it returns to IDLE at next edge
//   cfg_osr               beats per input sample (0 and 1 both mean 1),
//                         latched on the IDLE->PRIME transition only
//   clr_underflow         single-cycle clear of underflow flag and count
//   s_axis_data_*         audio-rate input stream (offset-binary samples)
//   m_axis_data_*         modulator-rate output stream
//   stat_running          high while in RUN
//   stat_underflow        sticky underflow flag
//   stat_underflow_cnt    saturating underflow count
// ---------------------------------------------------------------------------
module axis_mash_rate_ctrl #(
  parameter int WIDTH = 16,
  parameter int OSR_W = 16
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             cfg_enable,
  input  logic [OSR_W-1:0] cfg_osr,
  input  logic             clr_underflow,
  input  logic [WIDTH-1:0] s_axis_data_tdata,
  input  logic             s_axis_data_tvalid,
  output logic             s_axis_data_tready,
  output logic [WIDTH-1:0] m_axis_data_tdata,
  output logic             m_axis_data_tvalid,
  input  logic             m_axis_data_tready,
  output logic             stat_running,
  output logic             stat_underflow,
  output logic [15:0]      stat_underflow_cnt
);

  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [OSR_W-1:0] OSR_ONE = {{(OSR_W-1){1'b0}}, 1'b1};
  localparam logic [15:0] UF_MAX = 16'hFFFF;
  localparam logic [15:0] UF_ONE = 16'd1;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic             nxt_valid;
  logic [OSR_W-1:0] cnt;
  logic [OSR_W-1:0] osr_q;

  logic in_hs;
  logic beat;
  logic terminal;
  logic underflow_evt;

  assign in_hs    = s_axis_data_tvalid && s_axis_data_tready;
  assign beat     = m_axis_data_tvalid && m_axis_data_tready;
  assign terminal = (cnt == (osr_q - OSR_ONE));

  // A terminal beat with nothing buffered keeps the current sample on the
  // output and is recorded as an underflow.
  assign underflow_evt = (state == RUN) && beat && terminal && !nxt_valid;

  assign m_axis_data_tdata = cur;

  // State register.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Dropping cfg_enable wins over everything else.
  always_comb begin
    state_nxt = state;
    if (!cfg_enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = PRIME;
        PRIME:   if (s_axis_data_tvalid) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic. Ready depends only on the state register and nxt_valid, so
  // there is no combinational path from either tvalid or m_axis_data_tready.
  always_comb begin
    m_axis_data_tvalid = 1'b0;
    s_axis_data_tready = 1'b0;
    stat_running       = 1'b0;
    case (state)
      PRIME: begin
        s_axis_data_tready = 1'b1;
      end
      RUN: begin
        m_axis_data_tvalid = 1'b1;
        s_axis_data_tready = !nxt_valid;
        stat_running       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Sample datapath and beat counter. An input handshake in RUN needs
  // nxt_valid=0 and a swap needs nxt_valid=1, so the two updates of the
  // buffer can never land on the same edge.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      cur       <= MID;
      nxt       <= '0;
      nxt_valid <= 1'b0;
      cnt       <= '0;
      osr_q     <= OSR_ONE;
    end else if (!cfg_enable) begin
      cur       <= MID;
      nxt_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          osr_q <= (cfg_osr == '0) ? OSR_ONE : cfg_osr;
        end
        PRIME: begin
          if (in_hs) begin
            cur <= s_axis_data_tdata;
            cnt <= '0;
          end
        end
        RUN: begin
          if (in_hs) begin
            nxt       <= s_axis_data_tdata;
            nxt_valid <= 1'b1;
          end
          if (beat) begin
            if (terminal) begin
              cnt <= '0;
              if (nxt_valid) begin
                cur       <= nxt;
                nxt_valid <= 1'b0;
              end
            end else begin
              cnt <= cnt + OSR_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Underflow status. Only reset or clr_underflow clears it; a clear that
  // coincides with a new underflow leaves that underflow recorded.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      stat_underflow     <= 1'b0;
      stat_underflow_cnt <= '0;
    end else if (clr_underflow) begin
      stat_underflow     <= underflow_evt;
      stat_underflow_cnt <= underflow_evt ? UF_ONE : '0;
    end else if (underflow_evt) begin
      stat_underflow <= 1'b1;
      if (stat_underflow_cnt != UF_MAX) begin
        stat_underflow_cnt <= stat_underflow_cnt + UF_ONE;
      end
    end
  end

endmodule
